data_ram_read_arbiter: RTL and testbench
========================================

# data_ram_read_arbiter

Shares the two data-RAM read ports between the instruction decode unit (requester 0) and the host/IO memory-access unit (requester 1). It registers each granted request's address pair and waits the RAM read latency. It then captures both read rows into per-requester output registers and signals completion with a one-cycle valid pulse. A streak counter bounds how long decode traffic can starve the host.

## Interface

Parameters:
- DATA_ADDRESS_WIDTH, 16, data-RAM address width
- DATA_ROW_WIDTH, 96, data-RAM row width (3 x 32-bit lanes)
- RAM_LATENCY, 1, cycles from address presented to iRamValue valid; legal 1..7
- MAX_IDU_STREAK, 4, consecutive IDU grants allowed while the host waits; legal 1..15

Ports:
- Clock  input  1  sole clock; all state on posedge
- Reset  input  1  reset, asynchronous, active-low (0 = reset)
- iIduReq  input  1  IDU read request; level, held until oIduDataValid
- iIduAddr0, iIduAddr1  input  DATA_ADDRESS_WIDTH  IDU source addresses; stable while iIduReq=1
- oIduGrant  output  1  IDU owns the RAM ports
- oIduDataValid  output  1  one-cycle pulse; oIduValue0/1 updated
- oIduValue0, oIduValue1  output  DATA_ROW_WIDTH  IDU read data; held between captures
- iHostReq, iHostAddr0, iHostAddr1, oHostGrant, oHostDataValid, oHostValue0, oHostValue1: same semantics for the host
- oRamAddress0, oRamAddress1  output  DATA_ADDRESS_WIDTH  registered RAM read addresses
- iRamValue0, iRamValue1  input  DATA_ROW_WIDTH  RAM read data
- oBusy  output  1  1 whenever state != ARB_IDLE

## Operation

- FSM states:
  - ARB_IDLE: no access in progress.
  - ARB_WAIT: access issued; waiting RAM_LATENCY cycles.
  - ARB_DONE: data captured; valid pulse cycle.
- ARB_IDLE and ARB_DONE both arbitrate:
  - Winner found: latch winner's address pair into oRamAddress0/1, latch owner, load latency counter with RAM_LATENCY, go to ARB_WAIT.
  - No request: go to ARB_IDLE.
- ARB_WAIT: counter decrements each cycle. On the edge where the counter equals 1:
  - capture iRamValue0/1 into the owner's value registers;
  - go to ARB_DONE.
- ARB_DONE: owner's oXxxDataValid=1 for exactly this cycle.
  - A request still asserted in ARB_DONE is a new request; requesters drop req combinationally on valid if they want nothing more.
- Grant: oXxxGrant=1 for the owner throughout ARB_WAIT and ARB_DONE; 0 elsewhere. Never both 1.
- Priority, evaluated when both request:
  - IDU wins unless streak == MAX_IDU_STREAK; then the host wins.
  - A single requester always wins.
- Streak counter:
  - +1 (saturating at MAX_IDU_STREAK) on each IDU grant issued while iHostReq=1;
  - cleared on every host grant;
  - cleared on an IDU grant issued while iHostReq=0.
- Value registers of the non-owner are never written.
- Requests sampled in ARB_WAIT are ignored until the next arbitration cycle.

## Timing

- Reset asserted (any state, any time): immediately (asynchronously) go to ARB_IDLE. All outputs go to 0: grants, valids, values, RAM addresses, oBusy. Streak and counter clear. In-flight access is abandoned; no valid pulse follows.
- Request seen in ARB_IDLE at cycle T:
  - oRamAddress0/1 and grant valid from T+1;
  - capture edge at end of T+RAM_LATENCY;
  - oDataValid high in cycle T+RAM_LATENCY+1.
- Back-to-back: a request held through ARB_DONE issues immediately. Sustained throughput is one access per RAM_LATENCY+1 cycles.
- oRamAddress0/1 hold the last issued addresses when idle.
- All outputs are registered except oBusy and the grants, which decode from registered state/owner.

## Structure

- Shared package (alongside the existing definitions include):
  - state encodings ARB_IDLE/ARB_WAIT/ARB_DONE;
  - owner encodings OWNER_IDU=0 / OWNER_HOST=1;
  - DATA_ADDRESS_WIDTH / DATA_ROW_WIDTH macros, reused, not redefined.
- One sub-module, arb_starvation_counter: 4-bit saturating streak counter.
  - Inputs: inc, clear, Clock, Reset.
  - Output: oLimitReached (streak == MAX_IDU_STREAK).

## Test plan

- Reset mid-access: IDU req, Reset=0 during ARB_WAIT -> all outputs 0 at once. No oIduDataValid after release. Next request served normally.
- Single IDU read, RAM_LATENCY=1: req at T with addrs 0x0010/0x0011. RAM model returns row 96'hA.../96'hB... -> oRamAddress=0x0010/0x0011 and oIduGrant=1 at T+1. oIduDataValid=1 only at T+2 with those values. Host values stay 0.
- Fairness, MAX_IDU_STREAK=4, both requesting continuously -> completion order IDU,IDU,IDU,IDU,Host, then repeats. Never 5 consecutive IDU completions while the host waits.
- Host-only, RAM_LATENCY=3: host req at T -> oHostDataValid at T+4. oHostValue updated. oIduValue unchanged; streak 0.
- Back-to-back IDU, req held high, RAM_LATENCY=2 -> oIduDataValid pulses every 3 cycles. oRamAddress updates in each ARB_DONE-following cycle.
- Handover in ARB_DONE: IDU valid cycle with iIduReq dropped and iHostReq first raised -> host issued the next cycle (oHostGrant=1). No idle bubble.

Source files
------------

// File: rtl/data_ram_read_arbiter_pkg.sv
// Shared types and defaults for the data-RAM read arbiter: FSM states, owner
// encoding and the winner-selection rule.
package data_ram_read_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_ROW_WIDTH  = 96;
    localparam int STREAK_WIDTH       = 4;
    localparam int LAT_CNT_WIDTH      = 3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IDU  = 1'b0,
        OWNER_HOST = 1'b1
    } arb_owner_e;

    // Only meaningful when at least one request is present.
    function automatic arb_owner_e pick_winner(input logic idu_req,
                                               input logic host_req,
                                               input logic limit_reached);
        if (host_req && (!idu_req || limit_reached)) begin
            return OWNER_HOST;
        end
        return OWNER_IDU;
    endfunction

endpackage

// File: rtl/data_ram_read_arbiter_if.sv
// Requester, RAM and status signals of the data-RAM read arbiter; the arbiter
// takes the slave view, the requesters/RAM model take the master view.
interface data_ram_read_arbiter_if
    import data_ram_read_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ROW_WIDTH  = DEFAULT_ROW_WIDTH
) ();

    logic                  idu_req;
    logic [ADDR_WIDTH-1:0] idu_addr0;
    logic [ADDR_WIDTH-1:0] idu_addr1;
    logic                  idu_grant;
    logic                  idu_data_valid;
    logic [ROW_WIDTH-1:0]  idu_value0;
    logic [ROW_WIDTH-1:0]  idu_value1;

    logic                  host_req;
    logic [ADDR_WIDTH-1:0] host_addr0;
    logic [ADDR_WIDTH-1:0] host_addr1;
    logic                  host_grant;
    logic                  host_data_valid;
    logic [ROW_WIDTH-1:0]  host_value0;
    logic [ROW_WIDTH-1:0]  host_value1;

    logic [ADDR_WIDTH-1:0] ram_address0;
    logic [ADDR_WIDTH-1:0] ram_address1;
    logic [ROW_WIDTH-1:0]  ram_value0;
    logic [ROW_WIDTH-1:0]  ram_value1;

    logic                  busy;

    modport slave (
        input  idu_req, idu_addr0, idu_addr1,
        input  host_req, host_addr0, host_addr1,
        input  ram_value0, ram_value1,
        output idu_grant, idu_data_valid, idu_value0, idu_value1,
        output host_grant, host_data_valid, host_value0, host_value1,
        output ram_address0, ram_address1,
        output busy
    );

    modport master (
        output idu_req, idu_addr0, idu_addr1,
        output host_req, host_addr0, host_addr1,
        output ram_value0, ram_value1,
        input  idu_grant, idu_data_valid, idu_value0, idu_value1,
        input  host_grant, host_data_valid, host_value0, host_value1,
        input  ram_address0, ram_address1,
        input  busy
    );

endinterface

// File: rtl/data_ram_read_arbiter_starvation_counter.sv
// Saturating count of consecutive IDU grants issued while the host was waiting;
// flags when the host must be given the next contested slot.
module arb_starvation_counter
    import data_ram_read_arbiter_pkg::*;
#(
    parameter int MAX_IDU_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clear,
    output logic limit_reached
);

    localparam logic [STREAK_WIDTH-1:0] MAX_VAL = STREAK_WIDTH'(MAX_IDU_STREAK);

    logic [STREAK_WIDTH-1:0] streak_reg;
    logic [STREAK_WIDTH-1:0] streak_next;

    always_comb begin
        streak_next = streak_reg;
        if (clear) begin
            streak_next = '0;
        end else if (inc && (streak_reg != MAX_VAL)) begin
            streak_next = streak_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

    assign limit_reached = (streak_reg == MAX_VAL);

endmodule

// File: rtl/data_ram_read_arbiter.sv
// Shares the two data-RAM read ports between the IDU and the host: one access in
// flight, fixed RAM latency, per-requester result registers and a valid pulse.
module data_ram_read_arbiter
    import data_ram_read_arbiter_pkg::*;
#(
    parameter int DATA_ADDRESS_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_ROW_WIDTH     = DEFAULT_ROW_WIDTH,
    parameter int RAM_LATENCY        = 1,
    parameter int MAX_IDU_STREAK     = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    data_ram_read_arbiter_if.slave bus
);

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD = LAT_CNT_WIDTH'(RAM_LATENCY);
    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LAST = LAT_CNT_WIDTH'(1);

    arb_state_e                   state_reg;
    arb_state_e                   state_next;
    arb_owner_e                   owner_reg;
    arb_owner_e                   owner_next;
    logic [LAT_CNT_WIDTH-1:0]     lat_cnt_reg;
    logic [LAT_CNT_WIDTH-1:0]     lat_cnt_next;
    logic                         idu_valid_reg;
    logic                         idu_valid_next;
    logic                         host_valid_reg;
    logic                         host_valid_next;

    logic                         issue;
    logic                         capture;
    logic                         streak_inc;
    logic                         streak_clear;
    logic                         limit_reached;

    logic [1:0][DATA_ADDRESS_WIDTH-1:0] idu_addr;
    logic [1:0][DATA_ADDRESS_WIDTH-1:0] host_addr;
    logic [1:0][DATA_ROW_WIDTH-1:0]     ram_value;

    assign idu_addr  = {bus.idu_addr1, bus.idu_addr0};
    assign host_addr = {bus.host_addr1, bus.host_addr0};
    assign ram_value = {bus.ram_value1, bus.ram_value0};

    arb_starvation_counter #(
        .MAX_IDU_STREAK(MAX_IDU_STREAK)
    ) u_streak (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc          (streak_inc),
        .clear        (streak_clear),
        .limit_reached(limit_reached)
    );

    // IDLE and DONE both arbitrate, so a request held through DONE issues without a bubble.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        lat_cnt_next    = lat_cnt_reg;
        idu_valid_next  = 1'b0;
        host_valid_next = 1'b0;
        issue           = 1'b0;
        capture         = 1'b0;
        streak_inc      = 1'b0;
        streak_clear    = 1'b0;

        case (state_reg)
            ARB_IDLE, ARB_DONE: begin
                state_next = ARB_IDLE;
                if (bus.idu_req || bus.host_req) begin
                    issue        = 1'b1;
                    state_next   = ARB_WAIT;
                    owner_next   = pick_winner(bus.idu_req, bus.host_req, limit_reached);
                    lat_cnt_next = LAT_LOAD;
                    if ((owner_next == OWNER_IDU) && bus.host_req) begin
                        streak_inc = 1'b1;
                    end else begin
                        streak_clear = 1'b1;
                    end
                end
            end
            ARB_WAIT: begin
                lat_cnt_next = lat_cnt_reg - 1'b1;
                if (lat_cnt_reg == LAT_LAST) begin
                    capture         = 1'b1;
                    state_next      = ARB_DONE;
                    idu_valid_next  = (owner_reg == OWNER_IDU);
                    host_valid_next = (owner_reg == OWNER_HOST);
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= OWNER_IDU;
            lat_cnt_reg    <= '0;
            idu_valid_reg  <= 1'b0;
            host_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            lat_cnt_reg    <= lat_cnt_next;
            idu_valid_reg  <= idu_valid_next;
            host_valid_reg <= host_valid_next;
        end
    end

    // One slice per RAM port: issued address plus both requesters' result rows.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_ADDRESS_WIDTH-1:0] ram_address_reg;
        logic [DATA_ROW_WIDTH-1:0]     idu_value_reg;
        logic [DATA_ROW_WIDTH-1:0]     host_value_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ram_address_reg <= '0;
                idu_value_reg   <= '0;
                host_value_reg  <= '0;
            end else begin
                if (issue) begin
                    ram_address_reg <= (owner_next == OWNER_HOST) ? host_addr[gi] : idu_addr[gi];
                end
                if (capture && (owner_reg == OWNER_IDU)) begin
                    idu_value_reg <= ram_value[gi];
                end
                if (capture && (owner_reg == OWNER_HOST)) begin
                    host_value_reg <= ram_value[gi];
                end
            end
        end
    end

    assign bus.ram_address0    = g_port[0].ram_address_reg;
    assign bus.ram_address1    = g_port[1].ram_address_reg;
    assign bus.idu_value0      = g_port[0].idu_value_reg;
    assign bus.idu_value1      = g_port[1].idu_value_reg;
    assign bus.host_value0     = g_port[0].host_value_reg;
    assign bus.host_value1     = g_port[1].host_value_reg;

    assign bus.idu_data_valid  = idu_valid_reg;
    assign bus.host_data_valid = host_valid_reg;
    assign bus.busy            = (state_reg != ARB_IDLE);
    assign bus.idu_grant       = (state_reg != ARB_IDLE) && (owner_reg == OWNER_IDU);
    assign bus.host_grant      = (state_reg != ARB_IDLE) && (owner_reg == OWNER_HOST);

endmodule

// File: tb/tb_data_ram_read_arbiter.sv
// Bench for data_ram_read_arbiter: scripted vector table, reset and fairness
// sequences, then random traffic against a transaction-level reference model.
module tb_data_ram_read_arbiter;
    import data_ram_read_arbiter_pkg::*;

    localparam int AW   = 16;
    localparam int RW   = 96;
    localparam int LAT  = 2;
    localparam int MAXS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_ram_read_arbiter_if #(.ADDR_WIDTH(AW), .ROW_WIDTH(RW)) bus ();

    data_ram_read_arbiter #(
        .DATA_ADDRESS_WIDTH(AW),
        .DATA_ROW_WIDTH    (RW),
        .RAM_LATENCY       (LAT),
        .MAX_IDU_STREAK    (MAXS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // RAM contents are a fixed function of the address; data appears LAT cycles
    // after the address is presented, so misaligned capture returns wrong rows.
    function automatic logic [RW-1:0] row0(input logic [AW-1:0] a);
        return {a, 16'hA5A5, ~a, 16'h5A5A, a ^ 16'h1234, 16'hC3C3};
    endfunction

    function automatic logic [RW-1:0] row1(input logic [AW-1:0] a);
        return {16'hB00B, a, 16'h0F0F, a ^ 16'h8001, 16'h7E7E, ~a};
    endfunction

    logic [AW-1:0] hist0 [0:7];
    logic [AW-1:0] hist1 [0:7];
    initial begin
        for (int k = 0; k < 8; k++) begin
            hist0[k] = '0;
            hist1[k] = '0;
        end
    end
    always @(posedge clk) begin
        hist0[0] <= bus.ram_address0;
        hist1[0] <= bus.ram_address1;
        for (int k = 1; k < 8; k++) begin
            hist0[k] <= hist0[k-1];
            hist1[k] <= hist1[k-1];
        end
    end
    assign bus.ram_value0 = (LAT == 1) ? row0(bus.ram_address0) : row0(hist0[LAT-2]);
    assign bus.ram_value1 = (LAT == 1) ? row1(bus.ram_address1) : row1(hist1[LAT-2]);

    task automatic chk(input string name, input logic [383:0] got, input logic [383:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [4:0] flags();
        return {bus.idu_grant, bus.host_grant, bus.idu_data_valid, bus.host_data_valid, bus.busy};
    endfunction

    task automatic do_reset();
        bus.idu_req  = 1'b0;
        bus.host_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Vector table: inputs for cycle c and expected outputs observed in cycle c+1.
    typedef struct {
        bit            ireq;
        bit            hreq;
        logic [AW-1:0] iaddr;
        logic [AW-1:0] haddr;
        logic [4:0]    eflags;  // {idu_grant, host_grant, idu_valid, host_valid, busy}
        logic [AW-1:0] eaddr;
        logic [RW-1:0] eival;
        logic [RW-1:0] ehval;
    } vec_t;
    vec_t tbl [$];

    task automatic add(input bit ir, input bit hr, input logic [AW-1:0] ia, input logic [AW-1:0] ha,
                       input logic [4:0] f, input logic [AW-1:0] ea,
                       input logic [RW-1:0] iv, input logic [RW-1:0] hv);
        vec_t v;
        v.ireq = ir; v.hreq = hr; v.iaddr = ia; v.haddr = ha;
        v.eflags = f; v.eaddr = ea; v.eival = iv; v.ehval = hv;
        tbl.push_back(v);
    endtask

    // Transaction-level reference: an access won in cycle c owns the ports for
    // cycles c+1..c+LAT+1 and completes (valid + new data) in cycle c+LAT+1.
    bit            m_act;
    bit            m_host;
    int            m_done;
    int            m_streak;
    logic [4:0]    e_flags;
    logic [AW-1:0] e_a0, e_a1;
    logic [RW-1:0] e_iv0, e_iv1, e_hv0, e_hv1;

    task automatic model_reset();
        m_act = 0; m_host = 0; m_done = -1; m_streak = 0;
        e_flags = '0; e_a0 = '0; e_a1 = '0;
        e_iv0 = '0; e_iv1 = '0; e_hv0 = '0; e_hv1 = '0;
    endtask

    task automatic model_step(input int c, input bit ir, input bit hr,
                              input logic [AW-1:0] ia0, input logic [AW-1:0] ia1,
                              input logic [AW-1:0] ha0, input logic [AW-1:0] ha1);
        bit hw;
        bit done_next;
        if (!m_act || c == m_done) begin
            m_act = 0;
            if (ir || hr) begin
                hw = hr && (!ir || m_streak == MAXS);
                if (!hw && hr) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
                else           m_streak = 0;
                m_act  = 1;
                m_host = hw;
                m_done = c + LAT + 1;
                e_a0   = hw ? ha0 : ia0;
                e_a1   = hw ? ha1 : ia1;
            end
        end
        done_next = m_act && (c + 1 == m_done);
        if (done_next && !m_host) begin e_iv0 = row0(e_a0); e_iv1 = row1(e_a1); end
        if (done_next &&  m_host) begin e_hv0 = row0(e_a0); e_hv1 = row1(e_a1); end
        e_flags = {m_act && !m_host, m_act && m_host, done_next && !m_host, done_next && m_host, m_act};
    endtask

    initial begin
        logic [RW-1:0] r10, r20, r30, r40, r50, r60;
        logic [9:0]    order;
        int            got;
        bit            seen;

        bus.idu_req = 0; bus.idu_addr0 = '0; bus.idu_addr1 = '0;
        bus.host_req = 0; bus.host_addr0 = '0; bus.host_addr1 = '0;

        r10 = row0(16'h0010); r20 = row0(16'h0020); r30 = row0(16'h0030);
        r40 = row0(16'h0040); r50 = row0(16'h0050); r60 = row0(16'h0060);

        add(1, 0, 16'h0010, 16'h0000, 5'b10001, 16'h0010, '0,  '0);
        add(1, 0, 16'h0010, 16'h0000, 5'b10001, 16'h0010, '0,  '0);
        add(1, 0, 16'h0010, 16'h0000, 5'b10101, 16'h0010, r10, '0);
        add(0, 1, 16'h0010, 16'h0020, 5'b01001, 16'h0020, r10, '0);
        add(0, 1, 16'h0010, 16'h0020, 5'b01001, 16'h0020, r10, '0);
        add(0, 1, 16'h0010, 16'h0020, 5'b01011, 16'h0020, r10, r20);
        add(0, 0, 16'h0010, 16'h0020, 5'b00000, 16'h0020, r10, r20);
        add(0, 0, 16'h0010, 16'h0020, 5'b00000, 16'h0020, r10, r20);
        add(1, 0, 16'h0030, 16'h0020, 5'b10001, 16'h0030, r10, r20);
        add(1, 0, 16'h0030, 16'h0020, 5'b10001, 16'h0030, r10, r20);
        add(1, 0, 16'h0030, 16'h0020, 5'b10101, 16'h0030, r30, r20);
        add(1, 0, 16'h0040, 16'h0020, 5'b10001, 16'h0040, r30, r20);
        add(1, 0, 16'h0040, 16'h0020, 5'b10001, 16'h0040, r30, r20);
        add(1, 0, 16'h0040, 16'h0020, 5'b10101, 16'h0040, r40, r20);
        add(0, 0, 16'h0040, 16'h0020, 5'b00000, 16'h0040, r40, r20);
        add(1, 1, 16'h0050, 16'h0060, 5'b10001, 16'h0050, r40, r20);
        add(1, 1, 16'h0050, 16'h0060, 5'b10001, 16'h0050, r40, r20);
        add(1, 1, 16'h0050, 16'h0060, 5'b10101, 16'h0050, r50, r20);
        add(0, 1, 16'h0050, 16'h0060, 5'b01001, 16'h0060, r50, r20);
        add(0, 1, 16'h0050, 16'h0060, 5'b01001, 16'h0060, r50, r20);
        add(0, 1, 16'h0050, 16'h0060, 5'b01011, 16'h0060, r50, r60);
        add(0, 0, 16'h0050, 16'h0060, 5'b00000, 16'h0060, r50, r60);

        do_reset();
        chk("reset_flags", flags(), 5'b00000);
        chk("reset_addr", {bus.ram_address0, bus.ram_address1}, '0);
        chk("reset_vals", {bus.idu_value0, bus.idu_value1, bus.host_value0, bus.host_value1}, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.idu_req    = tbl[i].ireq;
            bus.idu_addr0  = tbl[i].iaddr;
            bus.idu_addr1  = tbl[i].iaddr + 16'd1;
            bus.host_req   = tbl[i].hreq;
            bus.host_addr0 = tbl[i].haddr;
            bus.host_addr1 = tbl[i].haddr + 16'd1;
            @(negedge clk);
            chk($sformatf("tbl%0d_flags", i), flags(), tbl[i].eflags);
            chk($sformatf("tbl%0d_addr", i), {bus.ram_address0, bus.ram_address1},
                {tbl[i].eaddr, tbl[i].eaddr + 16'd1});
            chk($sformatf("tbl%0d_idu_val", i), bus.idu_value0, tbl[i].eival);
            chk($sformatf("tbl%0d_host_val", i), bus.host_value0, tbl[i].ehval);
        end

        // Reset in the middle of an access clears everything at once.
        bus.idu_req = 1; bus.idu_addr0 = 16'h0070; bus.idu_addr1 = 16'h0071;
        @(negedge clk);
        chk("rst_pre_flags", flags(), 5'b10001);
        rst_n = 1'b0;
        #1;
        chk("rst_async_flags", flags(), 5'b00000);
        chk("rst_async_addr", {bus.ram_address0, bus.ram_address1}, '0);
        chk("rst_async_vals", {bus.idu_value0, bus.idu_value1, bus.host_value0, bus.host_value1}, '0);
        bus.idu_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.idu_data_valid | bus.idu_grant | bus.busy;
        end
        chk("rst_no_valid", seen, 1'b0);
        bus.idu_req = 1; bus.idu_addr0 = 16'h0080; bus.idu_addr1 = 16'h0081;
        @(negedge clk);
        chk("rst_after_flags1", flags(), 5'b10001);
        chk("rst_after_addr", {bus.ram_address0, bus.ram_address1}, {16'h0080, 16'h0081});
        @(negedge clk);
        chk("rst_after_flags2", flags(), 5'b10001);
        @(negedge clk);
        chk("rst_after_flags3", flags(), 5'b10101);
        chk("rst_after_vals", {bus.idu_value0, bus.idu_value1}, {row0(16'h0080), row1(16'h0081)});
        bus.idu_req = 0;
        @(negedge clk);
        chk("rst_after_idle", flags(), 5'b00000);

        // Fairness: both requesting continuously.
        do_reset();
        bus.idu_req = 1; bus.idu_addr0 = 16'h0100; bus.idu_addr1 = 16'h0101;
        bus.host_req = 1; bus.host_addr0 = 16'h0200; bus.host_addr1 = 16'h0201;
        got = 0;
        order = '0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            @(negedge clk);
            if (bus.idu_data_valid && got < 10) begin order[got] = 1'b0; got++; end
            if (bus.host_data_valid && got < 10) begin order[got] = 1'b1; got++; end
        end
        chk("fair_count", got, 10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("fair_order%0d", k), order[k], (k % 5 == 4) ? 1'b1 : 1'b0);
        end
        bus.idu_req = 0; bus.host_req = 0;

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            chk($sformatf("rnd%0d_flags", c), flags(), e_flags);
            chk($sformatf("rnd%0d_addr", c), {bus.ram_address0, bus.ram_address1}, {e_a0, e_a1});
            chk($sformatf("rnd%0d_vals", c),
                {bus.idu_value0, bus.idu_value1, bus.host_value0, bus.host_value1},
                {e_iv0, e_iv1, e_hv0, e_hv1});
            if (bus.idu_req) begin
                if (bus.idu_data_valid) begin
                    if ($urandom_range(0, 1) == 0) bus.idu_req = 0;
                    else begin
                        bus.idu_addr0 = AW'($urandom); bus.idu_addr1 = AW'($urandom);
                    end
                end
            end else if ($urandom_range(0, 9) < 4) begin
                bus.idu_req = 1;
                bus.idu_addr0 = AW'($urandom); bus.idu_addr1 = AW'($urandom);
            end
            if (bus.host_req) begin
                if (bus.host_data_valid) begin
                    if ($urandom_range(0, 1) == 0) bus.host_req = 0;
                    else begin
                        bus.host_addr0 = AW'($urandom); bus.host_addr1 = AW'($urandom);
                    end
                end
            end else if ($urandom_range(0, 9) < 4) begin
                bus.host_req = 1;
                bus.host_addr0 = AW'($urandom); bus.host_addr1 = AW'($urandom);
            end
            model_step(c, bus.idu_req, bus.host_req, bus.idu_addr0, bus.idu_addr1,
                       bus.host_addr0, bus.host_addr1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
